alu_reservation_station: RTL and testbench
==========================================

# alu_reservation_station

Tomasulo reservation station for the ALU/MUL/DIV execution units, the consumer of the decoder's issue bundle. It buffers up to `DEPTH` decoded operations and snoops the common data bus (CDB) for pending source operands. It issues the oldest operation whose operands are both present to its functional unit over a valid/ready handshake. It sits between the dispatch/rename stage and one execution unit; one instance is used per unit.

## Interface
- `DEPTH`, 4: number of entries, at least 2.
- `TAG_W`, 5: width of the rename tags. Tag 0 means "no dependency / value valid".
- `clk`  in  1  clock. One clock domain; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear of all entries (mispredict).
- `disp_valid`  in  1  dispatch offers an entry.
- `disp_ready`  out  1  the station accepts an entry; equals `!full`.
- `disp_op`  in  10  `{funct3, funct7}` operation code, as produced by decode.
- `disp_qj`, `disp_qk`  in  TAG_W  source tags. A value of 0 means the matching V is valid.
- `disp_vj`, `disp_vk`  in  32  source values.
- `disp_dest`  in  TAG_W  result tag.
- `cdb_valid`  in  1  a CDB broadcast is present this cycle.
- `cdb_tag`  in  TAG_W  tag of the broadcast result. Never 0 when valid.
- `cdb_value`  in  32  broadcast result value.
- `iss_valid`  out  1  a ready entry is presented to the unit.
- `iss_ready`  in  1  the unit accepts the entry.
- `iss_op`  out  10  operation code of the presented entry.
- `iss_vj`, `iss_vk`  out  32  operand values of the presented entry.
- `iss_dest`  out  TAG_W  result tag of the presented entry.
- `count`  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Each entry holds a busy bit, op, qj, qk, vj, vk and dest. Entries are kept as a compacting age-ordered queue: slot 0 is the oldest, and busy slots are always contiguous from 0.
- **Dispatch:** a handshake occurs when `disp_valid && disp_ready`. The new entry is written to slot `count` after any compaction from a same-cycle issue.
- **Dispatch bypass:** if `cdb_valid` is high and `cdb_tag` equals `disp_qj` (or `disp_qk`), the entry stores `cdb_value` in vj (or vk) and a tag of 0.
- **Snoop:** every busy entry with a nonzero `qj == cdb_tag` takes `vj <= cdb_value` and `qj <= 0`. The same rule applies to qk, and both may match in the same cycle.
- **Ready:** an entry is ready when it is busy and `qj == 0` and `qk == 0`. Ready is evaluated on registered state only.
- **Select:** `iss_*` shows the lowest-index ready slot, and `iss_valid` is high when any slot is ready. All of this is combinational from registers.
- **Issue:** a handshake occurs when `iss_valid && iss_ready`. The selected slot is removed, younger slots shift down by one, and the snoop update is applied to the shifted contents.
- **Same-cycle dispatch and issue:** both are allowed. `count` is unchanged, and the new entry lands in slot `count-1`.
- **Full:** when `count == DEPTH`, `disp_ready` is 0 and `disp_valid` is ignored. An issue in the same cycle does not open a slot for dispatch in that cycle.
- **Empty:** `iss_valid` is 0 and `iss_ready` is ignored.
- **Flush or reset:** all busy bits and `count` go to 0. Flush and reset both take priority over dispatch, issue and snoop in the same cycle.
- **Held output:** while `iss_valid && !iss_ready`, the presented entry may change only if an older entry becomes ready. The unit must not assume the payload stays stable across stall cycles.

## Timing
- **Reset values:** `count` 0, `disp_ready` 1, `iss_valid` 0. All `iss_*` payload outputs are 0 while `iss_valid` is 0.
- **Latency:** an entry dispatched with both tags equal to 0 (directly or by bypass) is presented on `iss_valid` one cycle after the dispatch edge.
- **Wakeup latency:** a CDB broadcast at cycle N makes a waiting entry presentable in cycle N+1.
- **Throughput:** one dispatch and one issue per cycle.
- `disp_ready` depends only on registered `count`; there is no combinational path from `iss_ready`.

## Structure
- **Shared package:** add `rs_entry_t` (busy, op[9:0], qj, qk, vj, vk, dest), the default `TAG_W` localparam and `TAG_NONE = '0`. These go alongside the existing `unit` and `ldst_mode` types.
- **Sub-module `rs_select`:** a parameterised priority encoder taking a `DEPTH`-bit ready vector and producing a one-hot grant, an index and an `any` flag.
- **Top level:** the entry array, the shift/compaction logic and the snoop comparators are in the top module.

## Test plan
- **Basic issue:** reset, then dispatch op=0x000, qj=qk=0, vj=5, vk=7, dest=3 with `iss_ready=1`. Required: `iss_valid` the next cycle with vj=5, vk=7, dest=3; `count` returns to 0.
- **Wakeup:** dispatch qj=9, vk=1, then hold `iss_ready=1`. Required: `iss_valid` stays 0 until a CDB broadcast of tag 9, value 0x1234; one cycle later the entry issues with vj=0x1234.
- **Bypass:** dispatch qj=6 in the same cycle as a CDB broadcast of tag 6, value 42. Required: the entry issues the next cycle with vj=42.
- **Ordering under stall:** fill 4 ready entries with dest 1, 2, 3, 4 while `iss_ready=0`. Required: `disp_ready=0` and a 5th dispatch is dropped. Then raise `iss_ready`; required issue order is 1, 2, 3, 4 on consecutive cycles.
- **Out-of-order wakeup:** the oldest entry waits on tag 7 and a younger entry is ready. Required: the younger entry issues first; after the tag 7 broadcast the older entry issues.
- **Flush:** with 3 busy entries, assert `flush` in the same cycle as a dispatch. Required: `count=0` and `iss_valid=0` on the next cycle, and the dispatched entry is not retained.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the issue path: functional-unit selectors, load/store modes
// and the reservation-station entry layout.
package alu_reservation_station_pkg;

    localparam int TAG_W = 5;
    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_MUL = 2'd1,
        UNIT_DIV = 2'd2,
        UNIT_LSU = 2'd3
    } unit_t;

    typedef enum logic [2:0] {
        LDST_BYTE  = 3'd0,
        LDST_HALF  = 3'd1,
        LDST_WORD  = 3'd2,
        LDST_BYTEU = 3'd4,
        LDST_HALFU = 3'd5
    } ldst_mode_t;

    typedef struct packed {
        logic             busy;
        logic [9:0]       op;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [TAG_W-1:0] dest;
    } rs_entry_t;

endpackage

// File: rtl/alu_reservation_station_rs_select.sv
// Lowest-index-wins priority encoder: one-hot grant, binary index and any flag.
module rs_select #(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Scan from the top so the lowest requester is the last write.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Compacting age-ordered reservation station: slot 0 is oldest, busy slots are
// contiguous, the oldest ready entry issues and the CDB is snooped every cycle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = alu_reservation_station_pkg::TAG_W,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [9:0]       disp_op,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic [TAG_W-1:0] disp_qk,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_vk,
    input  logic [TAG_W-1:0] disp_dest,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [9:0]       iss_op,
    output logic [31:0]      iss_vj,
    output logic [31:0]      iss_vk,
    output logic [TAG_W-1:0] iss_dest,
    output logic [CNT_W-1:0] count
);

    logic             busy_q [DEPTH];
    logic [9:0]       op_q   [DEPTH];
    logic [TAG_W-1:0] qj_q   [DEPTH];
    logic [TAG_W-1:0] qk_q   [DEPTH];
    logic [31:0]      vj_q   [DEPTH];
    logic [31:0]      vk_q   [DEPTH];
    logic [TAG_W-1:0] dest_q [DEPTH];
    logic [CNT_W-1:0] count_q;

    logic             busy_s [DEPTH];
    logic [9:0]       op_s   [DEPTH];
    logic [TAG_W-1:0] qj_s   [DEPTH];
    logic [TAG_W-1:0] qk_s   [DEPTH];
    logic [31:0]      vj_s   [DEPTH];
    logic [31:0]      vk_s   [DEPTH];
    logic [TAG_W-1:0] dest_s [DEPTH];

    logic             busy_d [DEPTH];
    logic [9:0]       op_d   [DEPTH];
    logic [TAG_W-1:0] qj_d   [DEPTH];
    logic [TAG_W-1:0] qk_d   [DEPTH];
    logic [31:0]      vj_d   [DEPTH];
    logic [31:0]      vk_d   [DEPTH];
    logic [TAG_W-1:0] dest_d [DEPTH];
    logic [CNT_W-1:0] count_d;

    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] sel_grant;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic             do_issue;
    logic             do_disp;
    logic [CNT_W-1:0] wr_pos;
    logic             byp_j;
    logic             byp_k;

    assign count      = count_q;
    assign disp_ready = (count_q != CNT_W'(DEPTH));
    assign do_disp    = disp_valid && disp_ready;
    assign do_issue   = sel_any && iss_ready;
    assign iss_valid  = sel_any;
    assign wr_pos     = count_q - CNT_W'(do_issue);
    assign byp_j      = cdb_valid && (disp_qj != TAG_NONE) && (disp_qj == cdb_tag);
    assign byp_k      = cdb_valid && (disp_qk != TAG_NONE) && (disp_qk == cdb_tag);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = busy_q[i] && (qj_q[i] == TAG_NONE) && (qk_q[i] == TAG_NONE);
        end
    end

    rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
        .req   (ready_vec),
        .grant (sel_grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    // Payload is AND-OR muxed by the grant so it reads 0 whenever nothing is ready.
    always_comb begin
        iss_op   = '0;
        iss_vj   = '0;
        iss_vk   = '0;
        iss_dest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_grant[i]) begin
                iss_op   = iss_op   | op_q[i];
                iss_vj   = iss_vj   | vj_q[i];
                iss_vk   = iss_vk   | vk_q[i];
                iss_dest = iss_dest | dest_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busy_s[i] = busy_q[i];
            op_s[i]   = op_q[i];
            dest_s[i] = dest_q[i];
            qj_s[i]   = qj_q[i];
            vj_s[i]   = vj_q[i];
            qk_s[i]   = qk_q[i];
            vk_s[i]   = vk_q[i];
            if (cdb_valid && qj_q[i] != TAG_NONE && qj_q[i] == cdb_tag) begin
                qj_s[i] = TAG_NONE;
                vj_s[i] = cdb_value;
            end
            if (cdb_valid && qk_q[i] != TAG_NONE && qk_q[i] == cdb_tag) begin
                qk_s[i] = TAG_NONE;
                vk_s[i] = cdb_value;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busy_d[i] = busy_s[i];
            op_d[i]   = op_s[i];
            qj_d[i]   = qj_s[i];
            qk_d[i]   = qk_s[i];
            vj_d[i]   = vj_s[i];
            vk_d[i]   = vk_s[i];
            dest_d[i] = dest_s[i];
        end
        // Close the gap left by the issued slot.
        if (do_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(sel_idx)) begin
                    busy_d[i] = busy_s[i+1];
                    op_d[i]   = op_s[i+1];
                    qj_d[i]   = qj_s[i+1];
                    qk_d[i]   = qk_s[i+1];
                    vj_d[i]   = vj_s[i+1];
                    vk_d[i]   = vk_s[i+1];
                    dest_d[i] = dest_s[i+1];
                end
            end
            busy_d[DEPTH-1] = 1'b0;
        end
        if (do_disp) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(wr_pos)) begin
                    busy_d[i] = 1'b1;
                    op_d[i]   = disp_op;
                    qj_d[i]   = byp_j ? TAG_NONE : disp_qj;
                    qk_d[i]   = byp_k ? TAG_NONE : disp_qk;
                    vj_d[i]   = byp_j ? cdb_value : disp_vj;
                    vk_d[i]   = byp_k ? cdb_value : disp_vk;
                    dest_d[i] = disp_dest;
                end
            end
        end
        count_d = count_q + CNT_W'(do_disp) - CNT_W'(do_issue);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i] <= 1'b0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i] <= busy_d[i];
                op_q[i]   <= op_d[i];
                qj_q[i]   <= qj_d[i];
                qk_q[i]   <= qk_d[i];
                vj_q[i]   <= vj_d[i];
                vk_q[i]   <= vk_d[i];
                dest_q[i] <= dest_d[i];
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with hand-computed expectations.
module tb_alu_reservation_station;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    logic [9:0]       disp_op;
    logic [TAG_W-1:0] disp_qj;
    logic [TAG_W-1:0] disp_qk;
    logic [31:0]      disp_vj;
    logic [31:0]      disp_vk;
    logic [TAG_W-1:0] disp_dest;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             iss_valid;
    logic             iss_ready;
    logic [9:0]       iss_op;
    logic [31:0]      iss_vj;
    logic [31:0]      iss_vk;
    logic [TAG_W-1:0] iss_dest;
    logic [CNT_W-1:0] count;

    int n_cmp;
    int n_bad;

    alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_op    (disp_op),
        .disp_qj    (disp_qj),
        .disp_qk    (disp_qk),
        .disp_vj    (disp_vj),
        .disp_vk    (disp_vk),
        .disp_dest  (disp_dest),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_value  (cdb_value),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_op     (iss_op),
        .iss_vj     (iss_vj),
        .iss_vk     (iss_vk),
        .iss_dest   (iss_dest),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [9:0] op, input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk,
                        input logic [31:0] vj, input logic [31:0] vk, input logic [TAG_W-1:0] dest);
        disp_valid = 1'b1;
        disp_op    = op;
        disp_qj    = qj;
        disp_qk    = qk;
        disp_vj    = vj;
        disp_vk    = vk;
        disp_dest  = dest;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_value = val;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1; flush = 1'b0; iss_ready = 1'b0;
        disp_valid = 1'b0; disp_op = '0; disp_qj = '0; disp_qk = '0;
        disp_vj = '0; disp_vk = '0; disp_dest = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        tick(); tick();
        reset = 1'b0;

        chk("rst_count", 32'(count), 0);
        chk("rst_disp_ready", 32'(disp_ready), 1);
        chk("rst_iss_valid", 32'(iss_valid), 0);
        chk("rst_iss_vj", iss_vj, 0);

        // Basic issue
        iss_ready = 1'b1;
        disp(10'h000, 0, 0, 5, 7, 3);
        tick();
        disp_valid = 1'b0;
        chk("basic_valid", 32'(iss_valid), 1);
        chk("basic_vj", iss_vj, 5);
        chk("basic_vk", iss_vk, 7);
        chk("basic_dest", 32'(iss_dest), 3);
        chk("basic_count1", 32'(count), 1);
        tick();
        chk("basic_count0", 32'(count), 0);
        chk("basic_idle", 32'(iss_valid), 0);

        // Wakeup
        disp(10'h015, 9, 0, 0, 1, 5);
        tick();
        disp_valid = 1'b0;
        chk("wake_wait1", 32'(iss_valid), 0);
        tick();
        chk("wake_wait2", 32'(iss_valid), 0);
        chk("wake_count", 32'(count), 1);
        cdb(9, 32'h1234);
        tick();
        cdb_valid = 1'b0;
        chk("wake_valid", 32'(iss_valid), 1);
        chk("wake_vj", iss_vj, 32'h1234);
        chk("wake_vk", iss_vk, 1);
        chk("wake_op", 32'(iss_op), 32'h015);
        tick();
        chk("wake_count0", 32'(count), 0);

        // Dispatch bypass
        disp(10'h001, 6, 0, 0, 3, 8);
        cdb(6, 42);
        tick();
        disp_valid = 1'b0; cdb_valid = 1'b0;
        chk("byp_valid", 32'(iss_valid), 1);
        chk("byp_vj", iss_vj, 42);
        chk("byp_dest", 32'(iss_dest), 8);
        tick();
        chk("byp_count0", 32'(count), 0);

        // Ordering under stall, full station
        iss_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            disp(10'h002, 0, 0, 32'(k), 0, TAG_W'(k));
            tick();
        end
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(disp_ready), 0);
        disp(10'h002, 0, 0, 99, 0, 9);
        tick();
        disp_valid = 1'b0;
        chk("full_drop_count", 32'(count), 4);
        chk("stall_head", 32'(iss_dest), 1);
        iss_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("order_valid", 32'(iss_valid), 1);
            chk("order_dest", 32'(iss_dest), k);
            tick();
        end
        chk("order_count0", 32'(count), 0);
        chk("order_empty", 32'(iss_valid), 0);

        // Out-of-order wakeup
        iss_ready = 1'b0;
        disp(10'h003, 7, 0, 0, 0, 10);
        tick();
        disp(10'h004, 0, 0, 11, 0, 11);
        tick();
        disp_valid = 1'b0;
        chk("ooo_young", 32'(iss_dest), 11);
        iss_ready = 1'b1;
        tick();
        chk("ooo_wait", 32'(iss_valid), 0);
        chk("ooo_count1", 32'(count), 1);
        cdb(7, 32'h77);
        tick();
        cdb_valid = 1'b0;
        chk("ooo_old_dest", 32'(iss_dest), 10);
        chk("ooo_old_vj", iss_vj, 32'h77);
        tick();
        chk("ooo_count0", 32'(count), 0);

        // Same-cycle dispatch and issue
        iss_ready = 1'b0;
        disp(10'h005, 0, 0, 1, 1, 20);
        tick();
        iss_ready = 1'b1;
        disp(10'h006, 0, 0, 2, 2, 21);
        chk("dual_head", 32'(iss_dest), 20);
        tick();
        disp_valid = 1'b0;
        chk("dual_count", 32'(count), 1);
        chk("dual_dest", 32'(iss_dest), 21);
        tick();
        chk("dual_count0", 32'(count), 0);

        // Both operands woken by one broadcast
        iss_ready = 1'b0;
        disp(10'h007, 4, 4, 0, 0, 22);
        tick();
        disp_valid = 1'b0;
        cdb(4, 32'h55);
        tick();
        cdb_valid = 1'b0;
        chk("both_valid", 32'(iss_valid), 1);
        chk("both_vj", iss_vj, 32'h55);
        chk("both_vk", iss_vk, 32'h55);
        iss_ready = 1'b1;
        tick();
        chk("both_count0", 32'(count), 0);

        // Flush with a concurrent dispatch
        iss_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            disp(10'h008, 0, 0, 0, 0, TAG_W'(k));
            tick();
        end
        chk("flush_pre_count", 32'(count), 3);
        flush = 1'b1;
        disp(10'h009, 0, 0, 0, 0, 12);
        tick();
        flush = 1'b0; disp_valid = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_valid", 32'(iss_valid), 0);
        chk("flush_dest", 32'(iss_dest), 0);
        tick();
        chk("flush_count_after", 32'(count), 0);
        chk("flush_valid_after", 32'(iss_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
